// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32 decode constants for the execute stage
package muldiv_pkg;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_BLT    = 3'b100;
  localparam logic [2:0] F3_BGE    = 3'b101;
  localparam logic [2:0] F3_BLTU   = 3'b110;
  localparam logic [2:0] F3_BGEU   = 3'b111;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  function automatic logic signed_a(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM;
  endfunction
  function automatic logic signed_b(input logic [2:0] f3);
    return f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 shift-add (multiply) or restoring (divide) step on a 64-bit accumulator
module muldiv_iter (
  input  logic [63:0] acc,
  input  logic [31:0] b,
  input  logic        div,
  output logic [63:0] nxt
);
  logic [32:0] sum;
  logic [32:0] diff;
  always_comb begin
    sum  = {1'b0, acc[63:32]} + {1'b0, b};
    diff = acc[63:31] - {1'b0, b};
    nxt  = div ? (diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
               : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative RV32M multiply/divide sequencer with pipeline stall and flush handling
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        stall_req
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] nxt;
  logic [63:0] prod;
  logic [31:0] b_r;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] special;
  logic [31:0] fixed;
  logic [2:0]  op;
  logic        neg_q;
  logic        neg_r;
  logic        sa;
  logic        sb;
  logic        dz;
  logic        ovf;
  muldiv_iter u_iter (.acc(acc), .b(b_r), .div(op[2]), .nxt(nxt));
  always_comb begin
    sa      = op_a[31] & signed_a(funct3);
    sb      = op_b[31] & signed_b(funct3);
    ma      = sa ? -op_a : op_a;
    mb      = sb ? -op_b : op_b;
    dz      = funct3[2] & (op_b == '0);
    ovf     = (funct3 == F3_DIV || funct3 == F3_REM) & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    special = dz ? (funct3[1] ? op_a : 32'hFFFF_FFFF) : (funct3[1] ? 32'h0 : 32'h8000_0000);
    prod    = neg_q ? -acc : acc;
    // after 32 divide steps the high word is the remainder, the low word the quotient
    fixed   = op == F3_MUL ? acc[31:0]
            : !op[2] ? prod[63:32]
            : op[1] ? (neg_r ? -acc[63:32] : acc[63:32])
            : (neg_q ? -acc[31:0] : acc[31:0]);
  end
  assign busy      = state != IDLE;
  assign stall_req = (state == IDLE && start) || state == CALC || state == FIX;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b_r    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op    <= funct3;
          acc   <= {32'h0, ma};
          b_r   <= mb;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt   <= '0;
          if (dz || ovf) begin
            result <= special;
            done   <= 1'b1;
            state  <= DONE;
          end else state <= CALC;
        end
        CALC: begin
          acc   <= nxt;
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : CALC;
        end
        FIX: begin
          result <= fixed;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed scoreboard bench for the RV32M multiply/divide sequencer
module tb_muldiv_ctrl;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic [31:0] result;
  int          checks = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last = '0;
  always #5 clk = ~clk;
  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result), .stall_req(stall_req)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit hold);
    logic got;
    got = 1'b0;
    exp_q.push_back(exp);
    funct3 = f3;
    op_a = a;
    op_b = b;
    start = 1'b1;
    #1;
    check({tag, " stall0"}, stall_req, 1);
    @(negedge clk);
    if (hold) begin
      funct3 = F3_MUL;
      op_a = 3;
      op_b = 3;
    end else start = 1'b0;
    for (int c = 1; c <= 60 && !got; c++) begin
      #1;
      if (done) begin
        got = 1'b1;
        start = 1'b0;
        check({tag, " latency"}, c, lat);
        check({tag, " result"}, result, exp_q.pop_front());
        check({tag, " stall_done"}, stall_req, 0);
        last = exp;
      end else check({tag, " stall"}, stall_req, 1);
      @(negedge clk);
    end
    check({tag, " done_seen"}, got, 1);
    #1;
    check({tag, " done_pulse"}, done, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst stall", stall_req, 0);
    reset = 1'b0;
    @(negedge clk);
    run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    run_op("mulh", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhu", F3_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    run_op("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_op("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 34, 0);
    run_op("remu_hold", F3_REMU, 32'd100, 32'd7, 32'd2, 34, 1);
    run_op("divu_z", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_z", F3_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    run_op("div_pre", F3_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
    funct3 = F3_MUL;
    op_a = 5;
    op_b = 6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      #1;
      check("flush no_done", done, 0);
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("flush busy_before", busy, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    check("flush result", result, last);
    run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 34, 0);
    funct3 = F3_DIV;
    op_a = 32'hFFFF_FFF9;
    op_b = 32'd2;
    start = 1'b1;
    @(negedge clk);
    funct3 = F3_MUL;
    op_a = 3;
    op_b = 3;
    repeat (19) begin
      #1;
      check("rstmid no_done", done, 0);
      check("rstmid busy", busy, 1);
      @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    #1;
    check("rstmid busy_after", busy, 0);
    check("rstmid done_after", done, 0);
    check("rstmid result_after", result, 0);
    check("rstmid stall_after", stall_req, 0);
    reset = 1'b0;
    @(negedge clk);
    run_op("remu_after_rst", F3_REMU, 32'd100, 32'd7, 32'd2, 34, 0);
    check("queue empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
